// File: rtl/grid_pkg.sv
// Shared types and geometry helpers for the grid solver.
package grid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE_OK,
        ST_DONE_FAIL
    } state_t;

    typedef enum logic {
        DIR_FWD,
        DIR_BACK
    } dir_t;

    // Number of symbols (and rows/columns) for a sub-grid order.
    function automatic int unsigned grid_len(input int unsigned ord);
        return ord * ord;
    endfunction

    // Number of cells for a sub-grid order.
    function automatic int unsigned grid_area(input int unsigned ord);
        return ord * ord * ord * ord;
    endfunction

    // Block number of a cell, counted row-major over the blocks.
    function automatic int unsigned blockof(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned ord);
        return (row / ord) * ord + (col / ord);
    endfunction

endpackage

// File: rtl/grid_solver_next_candidate.sv
// Picks the next free symbol strictly above the current one for a cell.
module next_candidate
    import grid_pkg::*;
#(
    parameter int unsigned LEN = 9
) (
    input  logic [LEN-1:0] cur_value,
    input  logic [LEN-1:0] occ,
    output logic           found,
    output logic [LEN-1:0] cand
);

    logic [LEN-1:0] allowed;
    logic [LEN-1:0] avail;

    // Mask off the current symbol and everything below it, then take the lowest free bit.
    always_comb begin
        if (cur_value == '0) begin
            allowed = '1;
        end else begin
            allowed = ~(cur_value | (cur_value - 1'b1));
        end
        avail = allowed & ~occ;
        cand  = avail & (~avail + 1'b1);
        found = |avail;
    end

endmodule

// File: rtl/grid_solver.sv
// Backtracking grid (sudoku-style) solver, one cell visited per cycle.
// Optional macro GRID_STEP_COUNT_EN builds the saturating search-cycle counter
// behind the steps output; without it steps is tied to zero.
module grid_solver
    import grid_pkg::*;
#(
    parameter  int unsigned ORD  = 3,
    localparam int unsigned LEN  = grid_len(ORD),
    localparam int unsigned AREA = grid_area(ORD),
    localparam int unsigned IW   = $clog2(AREA)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [IW-1:0]  load_index,
    input  logic [LEN-1:0] load_value,
    input  logic           clear,
    input  logic           start,
    output logic           busy,
    output logic           done_success,
    output logic           done_failure,
    input  logic [IW-1:0]  rd_index,
    output logic [LEN-1:0] rd_value,
    output logic [31:0]    steps
);

    localparam logic [IW:0] LAST = (IW + 1)'(AREA - 1);

    state_t          state;
    state_t          next_state;
    dir_t            dir;
    logic [IW:0]     ptr;
    logic [LEN-1:0]  values [AREA];
    logic [AREA-1:0] given;

    logic [IW-1:0]   cur;
    logic [LEN-1:0]  occ;
    logic [LEN-1:0]  cand;
    logic            found;
    logic            load_hit;
    logic            do_clear;
    logic            do_load;
    logic            do_start;
    logic            advance;
    logic            retreat;
    logic            write_cell;

    assign cur      = ptr[IW-1:0];
    assign load_hit = 32'(load_index) < AREA;

    // Combinational read port, out-of-range indices read as empty.
    always_comb begin
        rd_value = '0;
        if (32'(rd_index) < AREA) begin
            rd_value = values[rd_index];
        end
    end

    // Union of symbols held by every other cell sharing a row, column or block with cur.
    always_comb begin
        int unsigned prow;
        int unsigned pcol;
        int unsigned pblk;
        prow = 0;
        pcol = 0;
        pblk = 0;
        occ  = '0;
        for (int unsigned r = 0; r < LEN; r++) begin
            for (int unsigned c = 0; c < LEN; c++) begin
                if (IW'(r * LEN + c) == cur) begin
                    prow = r;
                    pcol = c;
                    pblk = blockof(r, c, ORD);
                end
            end
        end
        for (int unsigned r = 0; r < LEN; r++) begin
            for (int unsigned c = 0; c < LEN; c++) begin
                if (IW'(r * LEN + c) != cur &&
                    (r == prow || c == pcol || blockof(r, c, ORD) == pblk)) begin
                    occ = occ | values[IW'(r * LEN + c)];
                end
            end
        end
    end

    next_candidate #(
        .LEN(LEN)
    ) u_next_candidate (
        .cur_value (values[cur]),
        .occ       (occ),
        .found     (found),
        .cand      (cand)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, host-command decode and search-step decisions.
    always_comb begin
        next_state   = state;
        load_ready   = 1'b0;
        busy         = 1'b0;
        done_success = 1'b0;
        done_failure = 1'b0;
        do_clear     = 1'b0;
        do_load      = 1'b0;
        do_start     = 1'b0;
        advance      = 1'b0;
        retreat      = 1'b0;
        write_cell   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE_OK, ST_DONE_FAIL: begin
                load_ready   = 1'b1;
                done_success = (state == ST_DONE_OK);
                done_failure = (state == ST_DONE_FAIL);
                if (clear) begin
                    do_clear   = 1'b1;
                    next_state = ST_IDLE;
                end else if (load_valid) begin
                    do_load = load_hit;
                end else if (start) begin
                    do_start   = 1'b1;
                    next_state = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                busy = 1'b1;
                if (given[cur]) begin
                    if (dir == DIR_FWD) begin
                        if ((values[cur] & occ) != '0) begin
                            next_state = ST_DONE_FAIL;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        retreat = 1'b1;
                    end
                end else begin
                    write_cell = 1'b1;
                    advance    = found;
                    retreat    = !found;
                end
                if (advance && ptr == LAST) begin
                    next_state = ST_DONE_OK;
                end
                if (retreat && ptr == '0) begin
                    next_state = ST_DONE_FAIL;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Grid storage and search pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr   <= '0;
            dir   <= DIR_FWD;
            given <= '0;
            for (int unsigned i = 0; i < AREA; i++) begin
                values[IW'(i)] <= '0;
            end
        end else if (do_clear) begin
            given <= '0;
            for (int unsigned i = 0; i < AREA; i++) begin
                values[IW'(i)] <= '0;
            end
        end else if (do_load) begin
            values[load_index] <= load_value;
            given[load_index]  <= |load_value;
        end else if (do_start) begin
            ptr <= '0;
            dir <= DIR_FWD;
            for (int unsigned i = 0; i < AREA; i++) begin
                if (!given[IW'(i)]) begin
                    values[IW'(i)] <= '0;
                end
            end
        end else begin
            if (write_cell) begin
                values[cur] <= found ? cand : '0;
            end
            if (advance) begin
                ptr <= ptr + 1'b1;
                dir <= DIR_FWD;
            end else if (retreat) begin
                ptr <= ptr - 1'b1;
                dir <= DIR_BACK;
            end
        end
    end

`ifdef GRID_STEP_COUNT_EN
    logic [31:0] step_count;

    // Search-cycle counter, restarted by each start and saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset || do_start) begin
            step_count <= '0;
        end else if (busy && step_count != '1) begin
            step_count <= step_count + 32'd1;
        end
    end

    assign steps = step_count;
`else
    assign steps = '0;
`endif

endmodule

// File: tb/tb_grid_solver.sv
// Self-checking bench for grid_solver at ORD=2 (4 symbols, 16 cells).
module tb_grid_solver;

    localparam int O  = 2;
    localparam int L  = 4;
    localparam int A  = 16;
    localparam int IW = 4;

`ifdef GRID_STEP_COUNT_EN
    localparam bit COUNTS = 1'b1;
`else
    localparam bit COUNTS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] load_index = '0;
    logic [L-1:0]  load_value = '0;
    logic [IW-1:0] rd_index = '0;
    logic [L-1:0]  rd_value;
    logic          load_ready;
    logic          busy;
    logic          done_success;
    logic          done_failure;
    logic [31:0]   steps;

    grid_solver #(
        .ORD(O)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_index   (load_index),
        .load_value   (load_value),
        .clear        (clear),
        .start        (start),
        .busy         (busy),
        .done_success (done_success),
        .done_failure (done_failure),
        .rd_index     (rd_index),
        .rd_value     (rd_value),
        .steps        (steps)
    );

    always #20 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: symbols held as integers 0..L, 0 meaning empty.
    typedef enum {M_IDLE, M_SEARCH, M_OK, M_FAIL} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_ptr   = 0;
    bit      m_fwd   = 1'b1;
    int      m_steps = 0;
    int      m_val [A];
    bit      m_given [A];
    bit      m_valid = 1'b0;

    logic [L-1:0] dut_cells [A];

    logic [L-1:0] sol [A] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0100, 4'b1000, 4'b0001, 4'b0010,
                              4'b0010, 4'b0001, 4'b1000, 4'b0100,
                              4'b1000, 4'b0100, 4'b0010, 4'b0001};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int sym_of(logic [L-1:0] v);
        for (int b = 0; b < L; b++) begin
            if (v[b]) return b + 1;
        end
        return 0;
    endfunction

    function automatic logic [L-1:0] onehot_of(int s);
        logic [L-1:0] v;
        v = '0;
        if (s > 0) v[s-1] = 1'b1;
        return v;
    endfunction

    function automatic bit peer(int i, int j);
        int ri, ci, rj, cj;
        ri = i / L; ci = i % L; rj = j / L; cj = j % L;
        return (i != j) && (ri == rj || ci == cj || (ri / O == rj / O && ci / O == cj / O));
    endfunction

    task automatic model_move(bit fwd);
        m_fwd = fwd;
        if (fwd) begin
            m_ptr++;
            if (m_ptr == A) m_state = M_OK;
        end else begin
            m_ptr--;
            if (m_ptr < 0) m_state = M_FAIL;
        end
    endtask

    task automatic model_search();
        bit used [L+1];
        int pick;
        pick = 0;
        for (int s = 0; s <= L; s++) used[s] = 1'b0;
        for (int j = 0; j < A; j++) begin
            if (peer(m_ptr, j) && m_val[j] != 0) used[m_val[j]] = 1'b1;
        end
        if (m_given[m_ptr]) begin
            if (!m_fwd) begin
                model_move(1'b0);
            end else if (used[m_val[m_ptr]]) begin
                m_state = M_FAIL;
            end else begin
                model_move(1'b1);
            end
        end else begin
            for (int s = m_val[m_ptr] + 1; s <= L; s++) begin
                if (!used[s]) begin
                    pick = s;
                    break;
                end
            end
            m_val[m_ptr] = pick;
            model_move(pick != 0);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_state = M_IDLE; m_ptr = 0; m_fwd = 1'b1; m_steps = 0; m_valid = 1'b1;
            for (int i = 0; i < A; i++) begin m_val[i] = 0; m_given[i] = 1'b0; end
            return;
        end
        if (!m_valid) return;
        if (m_state == M_SEARCH) begin
            m_steps++;
            model_search();
        end else if (clear) begin
            m_state = M_IDLE;
            for (int i = 0; i < A; i++) begin m_val[i] = 0; m_given[i] = 1'b0; end
        end else if (load_valid) begin
            m_val[load_index]   = sym_of(load_value);
            m_given[load_index] = (load_value != '0);
        end else if (start) begin
            m_state = M_SEARCH; m_ptr = 0; m_fwd = 1'b1; m_steps = 0;
            for (int i = 0; i < A; i++) if (!m_given[i]) m_val[i] = 0;
        end
    endtask

    // Compare process: advance the model on each edge, then check every output and cell.
    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #1;
            for (int i = 0; i < A; i++) begin
                rd_index = IW'(i);
                #1;
                dut_cells[i] = rd_value;
            end
            if (m_valid) begin
                check("busy", busy, m_state == M_SEARCH);
                check("load_ready", load_ready, m_state != M_SEARCH);
                check("done_success", done_success, m_state == M_OK);
                check("done_failure", done_failure, m_state == M_FAIL);
                check("steps", steps, COUNTS ? 32'(m_steps) : 32'd0);
                for (int i = 0; i < A; i++) begin
                    check($sformatf("cell%0d", i), dut_cells[i], onehot_of(m_val[i]));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic do_load(int idx, logic [L-1:0] v);
        load_valid = 1'b1; load_index = IW'(idx); load_value = v;
        @(negedge clock);
        load_valid = 1'b0; load_value = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic run_search(output int kdone, output logic busy1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        busy1 = busy;
        kdone = 0;
        for (int k = 1; k <= 400; k++) begin
            if (done_success || done_failure) begin
                kdone = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic check_solution(string tag);
        for (int i = 0; i < A; i++) check($sformatf("%s_cell%0d", tag, i), dut_cells[i], sol[i]);
    endtask

    initial begin
        int   k;
        logic b1;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ok", done_success, 0);
        check("rst_fail", done_failure, 0);
        check("rst_steps", steps, 0);
        for (int i = 0; i < A; i++) check($sformatf("rst_cell%0d", i), dut_cells[i], 0);

        // Empty grid solves without backtracking in 16 cycles.
        run_search(k, b1);
        check("solve_busy_first", b1, 1);
        check("solve_done_cycle", k, 17);
        check("solve_ok", done_success, 1);
        check("solve_steps", steps, COUNTS ? 32'd16 : 32'd0);
        check_solution("solve");

        // Re-solve from DONE_OK gives the same outcome.
        run_search(k, b1);
        check("resolve_done_cycle", k, 17);
        check("resolve_steps", steps, COUNTS ? 32'd16 : 32'd0);
        check_solution("resolve");
        do_clear();
        check("clear_ready", load_ready, 1);
        check("clear_ok_low", done_success, 0);
        for (int i = 0; i < A; i++) check($sformatf("clear_cell%0d", i), dut_cells[i], 0);

        // Two equal givens in one row fail on the first search cycle.
        do_load(0, 4'b0001);
        do_load(1, 4'b0001);
        run_search(k, b1);
        check("dup_done_cycle", k, 2);
        check("dup_fail", done_failure, 1);
        check("dup_cell0", dut_cells[0], 4'b0001);
        check("dup_cell1", dut_cells[1], 4'b0001);
        check("dup_steps", steps, COUNTS ? 32'd1 : 32'd0);
        do_clear();

        // Cell 3 has no candidate; the walk back over givens fails below cell 0.
        do_load(0, 4'b0001);
        do_load(1, 4'b0010);
        do_load(2, 4'b0100);
        do_load(7, 4'b1000);
        run_search(k, b1);
        check("dead_done_cycle", k, 8);
        check("dead_fail", done_failure, 1);
        check("dead_steps", steps, COUNTS ? 32'd7 : 32'd0);
        check("dead_cell2", dut_cells[2], 4'b0100);
        for (int i = 3; i < A; i++) begin
            check($sformatf("dead_cell%0d", i), dut_cells[i], (i == 7) ? 4'b1000 : 4'b0000);
        end
        do_clear();

        // Host commands during SEARCH are ignored.
        do_load(15, 4'b0001);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("busy_ready_low", load_ready, 0);
        load_valid = 1'b1; load_index = 4'd5; load_value = 4'b1000; clear = 1'b1; start = 1'b1;
        @(negedge clock);
        load_valid = 1'b0; load_value = '0; clear = 1'b0; start = 1'b0;
        k = 0;
        for (int n = 4; n <= 400; n++) begin
            if (done_success || done_failure) begin
                k = n;
                break;
            end
            @(negedge clock);
        end
        check("ignore_done_cycle", k, 17);
        check("ignore_ok", done_success, 1);
        check_solution("ignore");

        // Reset in the middle of a search.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_ready", load_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_steps", steps, 0);
        for (int i = 0; i < A; i++) check($sformatf("mid_rst_cell%0d", i), dut_cells[i], 0);

        // Clear beats load; load beats start; a zero load empties a cell.
        do_load(4, 4'b0010);
        check("idle_load", dut_cells[4], 4'b0010);
        clear = 1'b1; load_valid = 1'b1; load_index = 4'd5; load_value = 4'b0100;
        @(negedge clock);
        clear = 1'b0; load_valid = 1'b0; load_value = '0;
        check("clear_wins_4", dut_cells[4], 0);
        check("clear_wins_5", dut_cells[5], 0);
        start = 1'b1; load_valid = 1'b1; load_index = 4'd6; load_value = 4'b1000;
        @(negedge clock);
        start = 1'b0; load_valid = 1'b0; load_value = '0;
        check("load_wins_busy", busy, 0);
        check("load_wins_cell", dut_cells[6], 4'b1000);
        do_load(6, 4'b0000);
        run_search(k, b1);
        check("empty_again_done", k, 17);
        check("empty_again_cell6", dut_cells[6], 4'b0001);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
